// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchronized RX, mid-bit sampling, glitch-start
// rejection, framing-error pulse and break hold-off before re-arming.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] word,
  output logic       ld,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sync1, r_rxs;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_sh, w_sh_nxt;
  logic [7:0]    r_word, w_word_nxt;
  logic          r_ld, w_ld_nxt;
  logic          r_fe, w_fe_nxt;
  logic          r_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_sh_nxt    = r_sh;
    w_word_nxt  = r_word;
    w_ld_nxt    = 1'b0;
    w_fe_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rxs) w_state_nxt = START;
      end
      START: begin
        // Line must still be low at mid start bit, otherwise it was a glitch.
        if (r_cnt == HALF) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = r_rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt = '0;
          w_sh_nxt  = {r_rxs, r_sh[7:1]};
          if (r_idx == 3'd7) w_state_nxt = STOP;
          else               w_idx_nxt   = r_idx + 3'd1;
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (r_cnt == LAST) begin
          w_cnt_nxt = '0;
          if (r_rxs) begin
            w_word_nxt  = r_sh;
            w_ld_nxt    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_fe_nxt    = 1'b1;
            w_state_nxt = BRK;
          end
        end
      end
      BRK: begin
        w_cnt_nxt = '0;
        if (r_rxs) w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_word  <= '0;
      r_ld    <= 1'b0;
      r_fe    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_sh    <= w_sh_nxt;
      r_word  <= w_word_nxt;
      r_ld    <= w_ld_nxt;
      r_fe    <= w_fe_nxt;
      r_busy  <= (r_state != IDLE);
    end
  end

  assign word      = r_word;
  assign ld        = r_ld;
  assign frame_err = r_fe;
  assign busy      = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are modelled as byte/event queues and
// compared against what the receiver reports.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] word;
  logic       ld, frame_err, busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .word(word), .ld(ld), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {bit fe; logic [7:0] data; int cyc;} ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];
  int nchk = 0, nerr = 0;
  int cyc = 0;
  int viol = 0;
  bit busy_seen = 0;
  bit ld_q = 0;
  logic [7:0] word_q = '0;
  logic [7:0] mdl_word = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    nchk++;
    if (got !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: collects reported events and tallies protocol violations.
  always @(negedge clk) begin
    if (ld)        obs_q.push_back('{1'b0, word, cyc});
    if (frame_err) obs_q.push_back('{1'b1, word, cyc});
    if (ld && frame_err) viol++;
    if (ld && ld_q) viol++;
    if (rst_n && !ld && word !== word_q) viol++;
    if (busy) busy_seen = 1'b1;
    ld_q   = ld;
    word_q = word;
  end

  task automatic send(input logic [7:0] b, input bit stop_ok, input real bit_ns);
    rx = 1'b0; #(bit_ns);
    for (int i = 0; i < 8; i++) begin rx = b[i]; #(bit_ns); end
    rx = stop_ok; #(bit_ns);
  endtask

  task automatic frame(input logic [7:0] b, input bit ok, input real bit_ns);
    if (ok) begin
      exp_q.push_back('{1'b0, b, 0});
      mdl_word = b;
    end else begin
      exp_q.push_back('{1'b1, mdl_word, 0});
    end
    send(b, ok, bit_ns);
  endtask

  task automatic wait_ev();
    int t;
    t = 0;
    while (obs_q.size() < exp_q.size() && t < 400) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    ev_t e, o;
    wait_ev();
    chk({tag, "_nev"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_kind"}, o.fe, e.fe);
      chk({tag, "_data"}, o.data, e.data);
    end
    exp_q.delete();
    obs_q.delete();
    chk({tag, "_word"}, word, mdl_word);
  endtask

  task automatic align();
    @(negedge clk); #2;
  endtask

  initial begin
    logic [7:0] a3;
    logic [7:0] b;
    bit ok;
    real bn;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_word", word, 8'h00);
    chk("rst_ld", ld, 1'b0);
    chk("rst_fe", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single clean byte
    align();
    frame(8'h2B, 1'b1, 160.0);
    #400;
    drain("single");

    // Back-to-back frames, no idle gap
    align();
    frame(8'h35, 1'b1, 160.0);
    frame(8'h3C, 1'b1, 160.0);
    frame(8'h39, 1'b1, 160.0);
    wait_ev();
    chk("b2b_cnt", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("b2b_gap1", obs_q[1].cyc - obs_q[0].cyc, 160);
      chk("b2b_gap2", obs_q[2].cyc - obs_q[1].cyc, 160);
    end
    drain("b2b");

    // Start-bit glitch
    align();
    busy_seen = 1'b0;
    rx = 1'b0; #50; rx = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("glitch_busy", busy, 1'b0);
    chk("glitch_busy_seen", busy_seen, 1'b1);
    drain("glitch");

    // Bad stop bit followed by a held break, then a clean byte
    align();
    frame(8'h55, 1'b0, 160.0);
    #1000;
    chk("brk_word", word, mdl_word);
    chk("brk_busy", busy, 1'b1);
    rx = 1'b1;
    #320;
    frame(8'h2D, 1'b1, 160.0);
    #400;
    drain("break");

    // Asynchronous reset in the middle of data bit 4
    a3 = 8'hA3;
    align();
    rx = 1'b0; #160;
    for (int i = 0; i < 4; i++) begin rx = a3[i]; #160; end
    rx = a3[4]; #80;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_word", word, 8'h00);
    chk("mid_rst_ld", ld, 1'b0);
    chk("mid_rst_fe", frame_err, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    mdl_word = 8'h00;
    rx = 1'b1;
    #50;
    rst_n = 1'b1;
    #500;
    align();
    frame(8'h3E, 1'b1, 160.0);
    #400;
    drain("after_rst");

    // Baud tolerance
    align();
    frame(8'h30, 1'b1, 155.0);
    #400;
    frame(8'h30, 1'b1, 165.0);
    #400;
    drain("baud");

    // Random frames, mixed baud, random gaps and stop errors
    align();
    for (int n = 0; n < 24; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 2))
        0:       bn = 155.0;
        1:       bn = 160.0;
        default: bn = 165.0;
      endcase
      frame(b, ok, bn);
      if (!ok) begin
        #($urandom_range(1, 6) * 160);
        rx = 1'b1;
        #320;
      end else begin
        #($urandom_range(0, 3) * 160);
      end
    end
    #400;
    drain("rand");

    chk("protocol_viol", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
